// File: rtl/nx_indirect_access_initiator.sv
// nx_indirect_access_initiator
// Register-bus master that turns one valid/ready request into an indirect
// access sequence: optional data write, command write, status polling until
// not busy (bounded), optional data read, then a valid/ready response.
module nx_indirect_access_initiator #(
  parameter logic [10:0] CMND_ADDRESS      = 11'h454,
  parameter logic [10:0] STAT_ADDRESS      = 11'h44C,
  parameter logic [10:0] DATA_ADDRESS      = 11'h450,
  parameter int          N_REG_ADDR_BITS   = 11,
  parameter int          N_DATA_BITS       = 32,
  parameter int          N_ENTRY_ADDR_BITS = 5,
  parameter int          POLL_LIMIT        = 64,
  parameter logic [3:0]  OP_READ           = 4'h0,
  parameter logic [3:0]  OP_WRITE          = 4'h1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_wr,
  input  logic [N_ENTRY_ADDR_BITS-1:0] req_addr,
  input  logic [N_DATA_BITS-1:0]       req_wdat,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [N_DATA_BITS-1:0]       resp_rdat,
  output logic [2:0]                   resp_code,
  output logic [N_REG_ADDR_BITS-1:0]   reg_addr,
  output logic                         reg_wr_stb,
  output logic [N_DATA_BITS-1:0]       reg_wr_dat,
  output logic                         reg_rd_stb,
  input  logic                         reg_rd_ack,
  input  logic [N_DATA_BITS-1:0]       reg_rd_dat
);

  // Poll counter is wide enough to hold POLL_LIMIT itself.
  localparam int CNT_W = $clog2(POLL_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(POLL_LIMIT);

  localparam logic [2:0] CODE_RDY = 3'd0;
  localparam logic [2:0] CODE_BSY = 3'd1;
  localparam logic [2:0] CODE_TMO = 3'd7;

  localparam logic [N_REG_ADDR_BITS-1:0] A_CMND = N_REG_ADDR_BITS'(CMND_ADDRESS);
  localparam logic [N_REG_ADDR_BITS-1:0] A_STAT = N_REG_ADDR_BITS'(STAT_ADDRESS);
  localparam logic [N_REG_ADDR_BITS-1:0] A_DATA = N_REG_ADDR_BITS'(DATA_ADDRESS);

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_CMND,
    POLL_REQ,
    POLL_WAIT,
    RD_REQ,
    RD_WAIT,
    RESP
  } state_t;

  state_t                         state;
  logic                           wr_q;
  logic [N_ENTRY_ADDR_BITS-1:0]   addr_q;
  logic [N_DATA_BITS-1:0]         wdat_q;
  logic [CNT_W-1:0]               poll_cnt;

  // Command word: opcode in the top nibble, entry address in the low bits.
  function automatic logic [N_DATA_BITS-1:0] cmnd_word(
    input logic [3:0]                   op,
    input logic [N_ENTRY_ADDR_BITS-1:0] entry
  );
    logic [N_DATA_BITS-1:0] w;
    w = '0;
    w[31:28] = op;
    w[N_ENTRY_ADDR_BITS-1:0] = entry;
    return w;
  endfunction

  // Sequencer: every bus output is registered and set on entry to the state
  // in which it must be visible, so strobes last exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdat_q     <= '0;
      poll_cnt   <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdat  <= '0;
      resp_code  <= '0;
      reg_addr   <= '0;
      reg_wr_stb <= 1'b0;
      reg_wr_dat <= '0;
      reg_rd_stb <= 1'b0;
    end else begin
      reg_wr_stb <= 1'b0;
      reg_rd_stb <= 1'b0;
      case (state)
        // Accept: latch the request; the first bus write goes out next cycle.
        IDLE: begin
          if (req_valid) begin
            wr_q       <= req_wr;
            addr_q     <= req_addr;
            wdat_q     <= req_wdat;
            req_ready  <= 1'b0;
            reg_wr_stb <= 1'b1;
            if (req_wr) begin
              reg_addr   <= A_DATA;
              reg_wr_dat <= req_wdat;
              state      <= WR_DATA;
            end else begin
              reg_addr   <= A_CMND;
              reg_wr_dat <= cmnd_word(OP_READ, req_addr);
              state      <= WR_CMND;
            end
          end
        end
        // Data register written; queue the command write.
        WR_DATA: begin
          reg_wr_stb <= 1'b1;
          reg_addr   <= A_CMND;
          reg_wr_dat <= cmnd_word(OP_WRITE, addr_q);
          state      <= WR_CMND;
        end
        // Command written; start polling with a fresh count.
        WR_CMND: begin
          poll_cnt   <= '0;
          reg_rd_stb <= 1'b1;
          reg_addr   <= A_STAT;
          state      <= POLL_REQ;
        end
        // Status read issued; count it.
        POLL_REQ: begin
          poll_cnt <= poll_cnt + CNT_W'(1);
          state    <= POLL_WAIT;
        end
        // Decide on the returned status code.
        POLL_WAIT: begin
          if (reg_rd_ack) begin
            if (reg_rd_dat[2:0] == CODE_BSY) begin
              if (poll_cnt < LIMIT) begin
                reg_rd_stb <= 1'b1;
                state      <= POLL_REQ;
              end else begin
                resp_code  <= CODE_TMO;
                resp_rdat  <= '0;
                resp_valid <= 1'b1;
                state      <= RESP;
              end
            end else if (reg_rd_dat[2:0] == CODE_RDY) begin
              if (!wr_q) begin
                reg_rd_stb <= 1'b1;
                reg_addr   <= A_DATA;
                state      <= RD_REQ;
              end else begin
                resp_code  <= CODE_RDY;
                resp_rdat  <= '0;
                resp_valid <= 1'b1;
                state      <= RESP;
              end
            end else begin
              resp_code  <= reg_rd_dat[2:0];
              resp_rdat  <= '0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end
          end
        end
        // Data read issued.
        RD_REQ: begin
          state <= RD_WAIT;
        end
        // Capture the entry contents.
        RD_WAIT: begin
          if (reg_rd_ack) begin
            resp_rdat  <= reg_rd_dat;
            resp_code  <= CODE_RDY;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        // Hold the response until consumed; accept again the cycle after.
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // wdat_q is kept for debug visibility of the accepted request.
  logic unused_wdat;
  assign unused_wdat = ^wdat_q;

endmodule

// File: tb/tb_nx_indirect_access_initiator.sv
// Directed bench for nx_indirect_access_initiator with a scripted
// register-bus responder that acks one cycle after each read strobe.
module tb_nx_indirect_access_initiator;

  localparam logic [10:0] A_CMND = 11'h454;
  localparam logic [10:0] A_STAT = 11'h44C;
  localparam logic [10:0] A_DATA = 11'h450;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [31:0] req_wdat = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdat;
  logic [2:0]  resp_code;
  logic [10:0] reg_addr;
  logic        reg_wr_stb;
  logic [31:0] reg_wr_dat;
  logic        reg_rd_stb;
  logic        reg_rd_ack = 1'b0;
  logic [31:0] reg_rd_dat = '0;

  nx_indirect_access_initiator #(.POLL_LIMIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdat   (req_wdat),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdat  (resp_rdat),
    .resp_code  (resp_code),
    .reg_addr   (reg_addr),
    .reg_wr_stb (reg_wr_stb),
    .reg_wr_dat (reg_wr_dat),
    .reg_rd_stb (reg_rd_stb),
    .reg_rd_ack (reg_rd_ack),
    .reg_rd_dat (reg_rd_dat)
  );

  always #5 clk = ~clk;

  // Responder script (written by the test, read by the responder)
  logic [11:0] cur_sseq = '0;
  logic [2:0]  cur_sfill = '0;
  logic [31:0] cur_rdata = '0;
  int          stat_base = 0;
  logic        stray = 1'b0;

  // Responder state and bus log
  logic        pend = 1'b0;
  logic [31:0] rd_pend = '0;
  int          stat_cnt = 0;
  int          dat_cnt = 0;
  int          wr_cnt = 0;
  int          viol = 0;
  logic [10:0] wr_addr_log [0:63];
  logic [31:0] wr_dat_log  [0:63];

  int total = 0;
  int bad = 0;

  function automatic logic [2:0] code_of(input int idx);
    logic [11:0] s;
    s = cur_sseq;
    if (idx < 4) return s[3*idx +: 3];
    return cur_sfill;
  endfunction

  // Upper status bits carry junk so only [2:0] may be decoded.
  function automatic logic [31:0] stat_word(input logic [2:0] c);
    return 32'hF0F0_F0F8 | {29'b0, c};
  endfunction

  always @(negedge clk) begin
    pend       <= reg_rd_stb;
    reg_rd_ack <= pend | stray;
    reg_rd_dat <= rd_pend;
    if (reg_rd_stb && reg_wr_stb) viol <= viol + 1;
    if (reg_rd_stb) begin
      if (reg_addr == A_STAT) begin
        rd_pend  <= stat_word(code_of(stat_cnt - stat_base));
        stat_cnt <= stat_cnt + 1;
      end else begin
        if (reg_addr == A_DATA) dat_cnt <= dat_cnt + 1;
        rd_pend <= cur_rdata;
      end
    end
    if (reg_wr_stb) begin
      wr_addr_log[wr_cnt] <= reg_addr;
      wr_dat_log[wr_cnt]  <= reg_wr_dat;
      wr_cnt              <= wr_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("resp_valid_seen", {31'b0, resp_valid}, 32'd1);
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_valid_drop", {31'b0, resp_valid}, 32'd0);
    chk("req_ready_back", {31'b0, req_ready}, 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdat;
    logic [11:0] sseq;   // status codes for polls 0..3, poll 0 in low bits
    logic [2:0]  sfill;  // status code for any later poll
    logic [31:0] rdata;
    logic [2:0]  ecode;
    logic [31:0] erdat;
    int          enstat;
    int          endat;
    int          elat;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int sb, db, wb, lat;
    logic [31:0] ecmd;
    cur_sseq  = v.sseq;
    cur_sfill = v.sfill;
    cur_rdata = v.rdata;
    stat_base = stat_cnt;
    sb = stat_cnt;
    db = dat_cnt;
    wb = wr_cnt;
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_wr    = v.wr;
    req_addr  = v.addr;
    req_wdat  = v.wdat;
    @(negedge clk);
    req_valid = 1'b0;
    req_wr    = ~v.wr;
    req_addr  = ~v.addr;
    req_wdat  = ~v.wdat;
    wait_resp(lat);
    chk("latency", lat, v.elat);
    chk("resp_code", {29'b0, resp_code}, {29'b0, v.ecode});
    chk("resp_rdat", resp_rdat, v.erdat);
    chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
    handshake();
    chk("status_reads", stat_cnt - sb, v.enstat);
    chk("data_reads", dat_cnt - db, v.endat);
    ecmd = {(v.wr ? 4'h1 : 4'h0), 23'b0, v.addr};
    if (v.wr) begin
      chk("bus_writes", wr_cnt - wb, 32'd2);
      chk("wr0_addr", {21'b0, wr_addr_log[wb]}, {21'b0, A_DATA});
      chk("wr0_dat", wr_dat_log[wb], v.wdat);
      chk("wr1_addr", {21'b0, wr_addr_log[wb+1]}, {21'b0, A_CMND});
      chk("wr1_dat", wr_dat_log[wb+1], ecmd);
    end else begin
      chk("bus_writes", wr_cnt - wb, 32'd1);
      chk("wr0_addr", {21'b0, wr_addr_log[wb]}, {21'b0, A_CMND});
      chk("wr0_dat", wr_dat_log[wb], ecmd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs [7];
    int   lat;
    int   wb;
    // wr addr wdat sseq sfill rdata ecode erdat enstat endat elat
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 12'h000, 3'd0, 32'h0,        3'd0, 32'h0,        1, 0, 4};
    vecs[1] = '{1'b0, 5'd31, 32'h0,        12'h049, 3'd0, 32'h12345678, 3'd0, 32'h12345678, 4, 1, 11};
    vecs[2] = '{1'b0, 5'd2,  32'h0,        12'h249, 3'd1, 32'hCAFEF00D, 3'd7, 32'h0,        4, 0, 9};
    vecs[3] = '{1'b0, 5'd7,  32'h0,        12'h003, 3'd0, 32'hCAFEF00D, 3'd3, 32'h0,        1, 0, 3};
    vecs[4] = '{1'b1, 5'd0,  32'hA5A50000, 12'h029, 3'd0, 32'h0,        3'd5, 32'h0,        2, 0, 6};
    vecs[5] = '{1'b1, 5'd10, 32'h00000001, 12'h249, 3'd1, 32'h0,        3'd7, 32'h0,        4, 0, 10};
    vecs[6] = '{1'b0, 5'd16, 32'h0,        12'h000, 3'd0, 32'hFFFFFFFF, 3'd0, 32'hFFFFFFFF, 1, 1, 5};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdat", resp_rdat, 32'd0);
    chk("rst_resp_code", {29'b0, resp_code}, 32'd0);
    chk("rst_reg_addr", {21'b0, reg_addr}, 32'd0);
    chk("rst_strobes", {30'b0, reg_wr_stb, reg_rd_stb}, 32'd0);
    chk("rst_reg_wr_dat", reg_wr_dat, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Stray ack in IDLE is ignored
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("stray_req_ready", {31'b0, req_ready}, 32'd1);
    chk("stray_rd_stb", {31'b0, reg_rd_stb}, 32'd0);

    // Response back-pressure, with a second request waiting
    cur_sseq  = 12'h000;
    cur_sfill = 3'd0;
    cur_rdata = 32'h0BADF00D;
    stat_base = stat_cnt;
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 5'd9;
    @(negedge clk);
    req_wr    = 1'b1;
    req_addr  = 5'd3;
    req_wdat  = 32'h55AA33CC;
    wait_resp(lat);
    chk("hold_latency", lat, 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_resp_rdat", resp_rdat, 32'h0BADF00D);
      chk("hold_resp_code", {29'b0, resp_code}, 32'd0);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    wb = wr_cnt;
    stat_base = stat_cnt;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("hold_resp_drop", {31'b0, resp_valid}, 32'd0);
    chk("hold_req_ready_back", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("next_accepted", {31'b0, req_ready}, 32'd0);
    wait_resp(lat);
    chk("next_latency", lat, 4);
    chk("next_resp_code", {29'b0, resp_code}, 32'd0);
    handshake();
    chk("next_wr0_dat", wr_dat_log[wb], 32'h55AA33CC);
    chk("next_wr1_dat", wr_dat_log[wb+1], 32'h10000003);

    // Reset during POLL_WAIT aborts the access
    cur_sseq  = 12'h249;
    cur_sfill = 3'd1;
    stat_base = stat_cnt;
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 5'd4;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!reg_rd_stb && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("abort_poll_seen", {31'b0, reg_rd_stb}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("abort_reg_addr", {21'b0, reg_addr}, 32'd0);
    chk("abort_strobes", {30'b0, reg_wr_stb, reg_rd_stb}, 32'd0);
    chk("abort_reg_wr_dat", reg_wr_dat, 32'd0);
    chk("abort_resp_code", {29'b0, resp_code}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_resp", {31'b0, resp_valid}, 32'd0);
    chk("abort_idle_ready", {31'b0, req_ready}, 32'd1);
    run_vec(vecs[0]);

    chk("strobe_overlap", viol, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
